rcl_stream: RTL

//  Streaming, parametrised line/circle relation classifier. Each query is a line a*x+b*y+c=0
//  and a circle (x-m)^2+(y-n)^2=k, delivered as a 3-beat triplet. Queries may arrive back-to-back.
//  The block computes one result per triplet through a fixed-latency, fully pipelined datapath.
//  It adds degenerate-line detection, partial-triplet abort and a result index.

---
 rtl/rcl_stream.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/rcl_stream.sv
`default_nettype none
// ============================================================================
//  Module   : rcl_stream
//  Purpose  : Streaming line/circle relation classifier. Each query arrives
//             as a 3-beat triplet (m,a | n,b | k,c) describing the line
//             a*x+b*y+c=0 and the circle (x-m)^2+(y-n)^2=k. One result per
//             triplet leaves a fixed-latency, fully pipelined datapath.
//  Ports    : clk       - clock, rising edge
//             rst_n     - asynchronous active-low reset
//             in_valid  - beat valid; a triplet is 3 consecutive high cycles
//             coef_Q    - beat0 m, beat1 n, beat2 k (unsigned)
//             coef_L    - beat0 a, beat1 b, beat2 c
//             out_valid - one-cycle pulse per completed triplet
//             out       - 0 none, 1 tangent, 2 two points, 3 degenerate line
//             out_idx   - sequence number of the result (wraps)
//  Revision : 1.0 - initial release
// ============================================================================
module rcl_stream #(
    parameter int W    = 5,
    parameter int IDXW = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    input  logic [W-1:0]    coef_Q,
    input  logic [W-1:0]    coef_L,
    output logic            out_valid,
    output logic [1:0]      out,
    output logic [IDXW-1:0] out_idx
);

    localparam logic [1:0] c_BEAT0 = 2'd0;
    localparam logic [1:0] c_BEAT1 = 2'd1;
    localparam logic [1:0] c_BEAT2 = 2'd2;

    // ------------------------------------------------------------------
    // Beat sequencer
    // ------------------------------------------------------------------
    logic [1:0] state_q, state_d;
    logic       w_cap0, w_cap1, w_launch;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= c_BEAT0;
        else        state_q <= state_d;
    end

    // A low in_valid at any point returns to beat0, which both aborts a
    // partial triplet and makes the next high cycle a fresh beat0.
    always_comb begin
        state_d = c_BEAT0;
        if (in_valid) begin
            case (state_q)
                c_BEAT0: state_d = c_BEAT1;
                c_BEAT1: state_d = c_BEAT2;
                default: state_d = c_BEAT0;
            endcase
        end
    end

    always_comb begin
        w_cap0   = in_valid && (state_q == c_BEAT0);
        w_cap1   = in_valid && (state_q == c_BEAT1);
        w_launch = in_valid && (state_q == c_BEAT2);
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    // Beat capture and launch stage
    logic signed [W-1:0]     m_q, m_d, a_q, a_d, n_q, n_d, b_q, b_d;
    logic                    v0_q, v0_d;
    logic [W-1:0]            k0_q, k0_d;
    logic signed [W-1:0]     c0_q, c0_d;
    // S1: products
    logic                    v1_q, v1_d, degen1_q, degen1_d;
    logic signed [2*W-1:0]   aa1_q, aa1_d, bb1_q, bb1_d, am1_q, am1_d, bn1_q, bn1_d;
    logic [W-1:0]            k1_q, k1_d;
    logic signed [W-1:0]     c1_q, c1_d;
    // S2: sums
    logic                    v2_q, v2_d, degen2_q, degen2_d;
    logic signed [2*W:0]     den2_q, den2_d;
    logic signed [2*W+1:0]   num2_q, num2_d;
    logic [W-1:0]            k2_q, k2_d;
    // S3: squared distance terms
    logic                    v3_q, v3_d, degen3_q, degen3_d;
    logic [4*W+3:0]          lhs3_q, lhs3_d, rhs3_q, rhs3_d;
    // S4: outputs
    logic                    out_valid_q, out_valid_d;
    logic [1:0]              out_q, out_d;
    logic [IDXW-1:0]         out_idx_q, out_idx_d, idx_cnt_q, idx_cnt_d;

    // ------------------------------------------------------------------
    // Operand extension. Every operand is widened to the result width
    // before multiplying so the products are exact at any W.
    // ------------------------------------------------------------------
    logic signed [2*W-1:0]   w_a_ext, w_b_ext, w_m_ext, w_n_ext;
    logic signed [4*W+3:0]   w_num_ext, w_num_sq;
    logic [4*W+3:0]          w_den_ext, w_k_ext;

    assign w_a_ext   = {{W{a_q[W-1]}}, a_q};
    assign w_b_ext   = {{W{b_q[W-1]}}, b_q};
    assign w_m_ext   = {{W{m_q[W-1]}}, m_q};
    assign w_n_ext   = {{W{n_q[W-1]}}, n_q};
    assign w_num_ext = {{(2*W+2){num2_q[2*W+1]}}, num2_q};
    assign w_num_sq  = w_num_ext * w_num_ext;
    // den is a sum of squares, hence non-negative: zero-extend it.
    assign w_den_ext = {{(2*W+3){1'b0}}, den2_q};
    assign w_k_ext   = {{(3*W+4){1'b0}}, k2_q};

    // ------------------------------------------------------------------
    // Next-state datapath
    // ------------------------------------------------------------------
    always_comb begin
        m_d = m_q;
        a_d = a_q;
        n_d = n_q;
        b_d = b_q;
        if (w_cap0) begin
            m_d = coef_Q;
            a_d = coef_L;
        end
        if (w_cap1) begin
            n_d = coef_Q;
            b_d = coef_L;
        end

        // k and c are held here; m,a,n,b stay stable until the edge that
        // loads S1 even when the next beat0 follows immediately.
        v0_d = w_launch;
        k0_d = w_launch ? coef_Q : k0_q;
        c0_d = w_launch ? coef_L : c0_q;

        v1_d     = v0_q;
        aa1_d    = w_a_ext * w_a_ext;
        bb1_d    = w_b_ext * w_b_ext;
        am1_d    = w_a_ext * w_m_ext;
        bn1_d    = w_b_ext * w_n_ext;
        degen1_d = (a_q == '0) && (b_q == '0);
        k1_d     = k0_q;
        c1_d     = c0_q;

        v2_d     = v1_q;
        den2_d   = {aa1_q[2*W-1], aa1_q} + {bb1_q[2*W-1], bb1_q};
        num2_d   = {{2{am1_q[2*W-1]}}, am1_q}
                 + {{2{bn1_q[2*W-1]}}, bn1_q}
                 + {{(W+2){c1_q[W-1]}}, c1_q};
        degen2_d = degen1_q;
        k2_d     = k1_q;

        v3_d     = v2_q;
        lhs3_d   = w_num_sq;
        rhs3_d   = w_den_ext * w_k_ext;
        degen3_d = degen2_q;

        // Output stage: out is only non-zero during the pulse; out_idx
        // latches the running count and holds it until the next result.
        out_valid_d = v3_q;
        out_d       = 2'd0;
        out_idx_d   = out_idx_q;
        idx_cnt_d   = idx_cnt_q;
        if (v3_q) begin
            if (degen3_q)               out_d = 2'd3;
            else if (lhs3_q == rhs3_q)  out_d = 2'd1;
            else if (lhs3_q < rhs3_q)   out_d = 2'd2;
            else                        out_d = 2'd0;
            out_idx_d = idx_cnt_q;
            idx_cnt_d = idx_cnt_q + {{(IDXW-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q         <= '0;
            a_q         <= '0;
            n_q         <= '0;
            b_q         <= '0;
            v0_q        <= 1'b0;
            k0_q        <= '0;
            c0_q        <= '0;
            v1_q        <= 1'b0;
            aa1_q       <= '0;
            bb1_q       <= '0;
            am1_q       <= '0;
            bn1_q       <= '0;
            degen1_q    <= 1'b0;
            k1_q        <= '0;
            c1_q        <= '0;
            v2_q        <= 1'b0;
            den2_q      <= '0;
            num2_q      <= '0;
            degen2_q    <= 1'b0;
            k2_q        <= '0;
            v3_q        <= 1'b0;
            lhs3_q      <= '0;
            rhs3_q      <= '0;
            degen3_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_q       <= 2'd0;
            out_idx_q   <= '0;
            idx_cnt_q   <= '0;
        end else begin
            m_q         <= m_d;
            a_q         <= a_d;
            n_q         <= n_d;
            b_q         <= b_d;
            v0_q        <= v0_d;
            k0_q        <= k0_d;
            c0_q        <= c0_d;
            v1_q        <= v1_d;
            aa1_q       <= aa1_d;
            bb1_q       <= bb1_d;
            am1_q       <= am1_d;
            bn1_q       <= bn1_d;
            degen1_q    <= degen1_d;
            k1_q        <= k1_d;
            c1_q        <= c1_d;
            v2_q        <= v2_d;
            den2_q      <= den2_d;
            num2_q      <= num2_d;
            degen2_q    <= degen2_d;
            k2_q        <= k2_d;
            v3_q        <= v3_d;
            lhs3_q      <= lhs3_d;
            rhs3_q      <= rhs3_d;
            degen3_q    <= degen3_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            out_idx_q   <= out_idx_d;
            idx_cnt_q   <= idx_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out       = out_q;
    assign out_idx   = out_idx_q;

endmodule
`default_nettype wire
